clk_div_bank: RTL and testbench

Parametrised, fully synchronous multi-channel clock divider; the next generation of the team's ripple-flop divider.
- Every channel runs on the single `clk`; no derived clocks are produced.
- Each channel produces a one-cycle enable pulse (`tick`) and a near-50% divided waveform (`div_out`) with a runtime-programmable period.
- A masked AND of channel waveforms replaces the fixed div2&div8 product.
- Sits between the top-level clock input and downstream blocks that consume enables or slow strobes.

---
 rtl/clk_div_pkg.sv | 31 +++
 rtl/clk_div_chan.sv | 92 +++++++++
 rtl/clk_div_bank.sv | 88 ++++++++
 tb/tb_clk_div_bank.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared constants and helper functions for the clock divider
//                bank: channel-index width, half-period computation and the
//                per-channel reset divisor.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    // Widest divisor the helpers support; half_of() works one bit wider so
    // that (div + 2) never overflows even for an all-ones divisor.
    localparam int MAX_DW = 32;

    // Width of a channel-select field; a single channel still needs one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // ceil(P/2) where P = div + 1, i.e. the number of high cycles per period.
    function automatic logic [MAX_DW:0] half_of(input logic [MAX_DW-1:0] div);
        return ({1'b0, div} + (MAX_DW+1)'(2)) >> 1;
    endfunction

    // Reset divisor of channel i: 2^(i+1)-1 in cascade mode, else 1 (P=2).
    function automatic int def_div(input int i, input int cascade);
        return (cascade != 0) ? ((2 ** (i + 1)) - 1) : 1;
    endfunction

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_chan
//  Description : One divider channel. Counts enabled cycles modulo P=div+1,
//                emits a one-cycle tick at each wrap and a near-50% waveform
//                (extra cycle high for odd P). Divisor writes are staged in
//                r_div_pend and take effect at the next wrap or sync.
//  Ports       : clk       - system clock
//                rst       - synchronous active-high reset
//                i_en      - count enable
//                i_sync    - restart the channel (phase align)
//                i_wr      - divisor write strobe for this channel
//                i_wdata   - divisor value (P = i_wdata + 1)
//                o_tick    - registered one-cycle wrap pulse
//                o_div_out - registered divided waveform
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DW      = 8,
    parameter int DEF_DIV = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_sync,
    input  logic          i_wr,
    input  logic [DW-1:0] i_wdata,
    output logic          o_tick,
    output logic          o_div_out
);

    localparam logic [DW-1:0] C_DEF_DIV = DW'(DEF_DIV);

    logic [DW-1:0]   r_cnt;
    logic [DW-1:0]   r_div_act;
    logic [DW-1:0]   r_div_pend;
    logic            r_tick;
    logic            r_div_out;

    logic            w_wrap;
    logic [DW-1:0]   w_cnt_next;
    logic [DW-1:0]   w_div_next;
    logic [MAX_DW:0] w_half_next;

    // Next-state values for an enabled cycle. The waveform is derived from
    // the post-update count and divisor so that the first cycle of a new
    // period already reflects the newly applied divisor.
    always_comb begin
        w_wrap      = (r_cnt == r_div_act);
        w_cnt_next  = w_wrap ? '0 : (r_cnt + DW'(1));
        w_div_next  = w_wrap ? r_div_pend : r_div_act;
        w_half_next = half_of(MAX_DW'(w_div_next));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_div_act  <= C_DEF_DIV;
            r_div_pend <= C_DEF_DIV;
            r_tick     <= 1'b0;
            r_div_out  <= 1'b0;
        end else begin
            // A write always lands in the staging register; a write during a
            // wrap is therefore picked up at the following wrap.
            if (i_wr) begin
                r_div_pend <= i_wdata;
            end

            if (i_sync) begin
                r_cnt     <= '0;
                // Write-through: a write coinciding with sync is used at once.
                r_div_act <= i_wr ? i_wdata : r_div_pend;
                r_tick    <= 1'b0;
                r_div_out <= 1'b1;
            end else if (i_en) begin
                r_cnt     <= w_cnt_next;
                r_div_act <= w_div_next;
                r_tick    <= w_wrap;
                r_div_out <= ((MAX_DW+1)'(w_cnt_next) < w_half_next);
            end else begin
                r_tick    <= 1'b0;
            end
        end
    end

    assign o_tick    = r_tick;
    assign o_div_out = r_div_out;

endmodule : clk_div_chan
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_bank
//  Description : Multi-channel synchronous clock divider. All channels run on
//                clk and produce enable ticks plus divided waveforms; a
//                masked AND of the waveforms is registered onto combo_out.
//  Ports       : clk        - system clock
//                reset      - synchronous active-low reset
//                en         - global count enable
//                sync       - restart all channels together
//                cfg_we     - divisor write strobe
//                cfg_ch     - channel selected by the write
//                cfg_div    - new divisor (P = cfg_div + 1)
//                combo_mask - channels included in combo_out
//                tick       - per-channel one-cycle pulses
//                div_out    - per-channel divided waveforms
//                combo_out  - registered AND of the masked div_out bits
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter  int NCH         = 4,
    parameter  int DW          = 8,
    parameter  int CASCADE_DEF = 1,
    localparam int CH_W        = ch_width(NCH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            sync,
    input  logic            cfg_we,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic [DW-1:0]   cfg_div,
    input  logic [NCH-1:0]  combo_mask,
    output logic [NCH-1:0]  tick,
    output logic [NCH-1:0]  div_out,
    output logic            combo_out
);

    logic            w_rst;
    logic [NCH-1:0]  w_wr;
    logic [NCH-1:0]  w_tick;
    logic [NCH-1:0]  w_div_out;
    logic            r_combo;

    // Channels use an active-high reset internally.
    assign w_rst = ~reset;

    // Out-of-range cfg_ch values match no channel and are thus ignored.
    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            localparam int unsigned C_IDX = i;

            assign w_wr[i] = cfg_we && (32'(cfg_ch) == C_IDX);

            clk_div_chan #(
                .DW      (DW),
                .DEF_DIV (def_div(i, CASCADE_DEF))
            ) u_chan (
                .clk       (clk),
                .rst       (w_rst),
                .i_en      (en),
                .i_sync    (sync),
                .i_wr      (w_wr[i]),
                .i_wdata   (cfg_div),
                .o_tick    (w_tick[i]),
                .o_div_out (w_div_out[i])
            );
        end
    endgenerate

    // Unmasked channels read as 1 in the reduction; an empty mask would make
    // the AND trivially true, so it is forced low instead.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_combo <= 1'b0;
        end else begin
            r_combo <= (|combo_mask) && (&(w_div_out | ~combo_mask));
        end
    end

    assign tick      = w_tick;
    assign div_out   = w_div_out;
    assign combo_out = r_combo;

endmodule : clk_div_bank
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_bank
//  Description : Self-checking bench for clk_div_bank. A driver applies
//                directed and random stimulus each cycle and pushes the
//                expected outputs (from a period/countdown model) into a
//                queue; a monitor pops and compares after each posedge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_bank;

    localparam int NCH  = 6;
    localparam int DW   = 8;
    localparam int CH_W = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            en;
    logic            sync;
    logic            cfg_we;
    logic [CH_W-1:0] cfg_ch;
    logic [DW-1:0]   cfg_div;
    logic [NCH-1:0]  combo_mask;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  div_out;
    logic            combo_out;

    always #5 clk = ~clk;

    clk_div_bank #(
        .NCH         (NCH),
        .DW          (DW),
        .CASCADE_DEF (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .sync       (sync),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .combo_mask (combo_mask),
        .tick       (tick),
        .div_out    (div_out),
        .combo_out  (combo_out)
    );

    typedef struct packed {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] div;
        logic           combo;
    } exp_t;

    exp_t q[$];

    // Reference model: each channel is described by its active period, its
    // staged period and the number of enabled cycles remaining until the
    // next tick.
    int             p_act  [NCH];
    int             p_pend [NCH];
    int             rem    [NCH];
    logic [NCH-1:0] m_div = '0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic drive(input logic r, input logic e, input logic s,
                         input logic we, input int ch, input int dv,
                         input logic [NCH-1:0] mask);
        exp_t           x;
        logic [NCH-1:0] nt;
        logic [NCH-1:0] nd;
        @(negedge clk);
        reset      = r;
        en         = e;
        sync       = s;
        cfg_we     = we;
        cfg_ch     = CH_W'(ch);
        cfg_div    = DW'(dv);
        combo_mask = mask;
        nt = '0;
        nd = m_div;
        if (!r) begin
            for (int i = 0; i < NCH; i++) begin
                p_act[i]  = 2 ** (i + 1);
                p_pend[i] = p_act[i];
                rem[i]    = p_act[i];
            end
            nd      = '0;
            x.combo = 1'b0;
        end else begin
            x.combo = (mask != '0) && ((m_div | ~mask) == '1);
            if (s) begin
                if (we && ch < NCH) p_pend[ch] = dv + 1;
                for (int i = 0; i < NCH; i++) begin
                    p_act[i] = p_pend[i];
                    rem[i]   = p_act[i];
                end
                nd = '1;
            end else begin
                if (e) begin
                    for (int i = 0; i < NCH; i++) begin
                        rem[i] = rem[i] - 1;
                        if (rem[i] == 0) begin
                            nt[i]    = 1'b1;
                            p_act[i] = p_pend[i];
                            rem[i]   = p_act[i];
                        end
                        // High for the first ceil(P/2) cycles of each period.
                        nd[i] = ((p_act[i] - rem[i]) < ((p_act[i] + 1) / 2));
                    end
                end
                if (we && ch < NCH) p_pend[ch] = dv + 1;
            end
        end
        m_div = nd;
        x.tick = nt;
        x.div  = nd;
        q.push_back(x);
    endtask

    task automatic idle(input int n, input logic e, input logic [NCH-1:0] mask);
        for (int k = 0; k < n; k++) drive(1'b1, e, 1'b0, 1'b0, 0, 0, mask);
    endtask

    // Monitor: outputs are presented every cycle; compare one cycle after
    // the corresponding stimulus, away from the active edge.
    exp_t mon_x;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                mon_x = q.pop_front();
                checks++;
                if (tick !== mon_x.tick) begin
                    errors++;
                    $display("FAIL tick cycle %0d got %b exp %b", cyc, tick, mon_x.tick);
                end
                checks++;
                if (div_out !== mon_x.div) begin
                    errors++;
                    $display("FAIL div_out cycle %0d got %b exp %b", cyc, div_out, mon_x.div);
                end
                checks++;
                if (combo_out !== mon_x.combo) begin
                    errors++;
                    $display("FAIL combo_out cycle %0d got %b exp %b", cyc, combo_out, mon_x.combo);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; en = 1'b0; sync = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_div = '0; combo_mask = '0;

        // Reset defaults, then free running at cascade periods.
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, '0);
        idle(70, 1'b1, '0);

        // Odd divisor on channel 1 (P=5), applied at its next wrap.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1, 4, '0);
        idle(30, 1'b1, '0);

        // Enable gap of 7 cycles mid-period.
        idle(3, 1'b1, '0);
        idle(7, 1'b0, '0);
        idle(20, 1'b1, '0);

        // sync with a simultaneous write-through on channel 2 (P=3).
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2, 2, '0);
        idle(20, 1'b1, '0);

        // combo_out with mask 0101, then empty mask, then invalid channels.
        idle(40, 1'b1, 6'b000101);
        idle(10, 1'b1, '0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 6, 0, 6'b000011);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 7, 0, 6'b000011);
        idle(40, 1'b1, 6'b000011);

        // Maximum divisor (P=256) on channel 0.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 0, 255, 6'b000001);
        idle(530, 1'b1, 6'b000001);

        // Reset mid-period with a pending write: pending value is lost.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 0, 9, '0);
        idle(2, 1'b1, '0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, '0);
        idle(40, 1'b1, 6'b111111);

        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            int dsel;
            int dv;
            dsel = int'($urandom_range(0, 99));
            if (dsel < 25)      dv = 0;
            else if (dsel < 30) dv = 255;
            else                dv = int'($urandom_range(1, 12));
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 7)),
                  dv,
                  NCH'($urandom));
        end

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clk_div_bank
`default_nettype wire
